// File: rtl/dual_issue_scoreboard.sv
// Dual-issue control: per-register busy countdowns for in-flight long ops,
// pair issue decision (in-order, intra-pair RAW, one long op per cycle) and a stall counter.

module dual_issue_reg_cnt #(
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);
    logic [CNT_W-1:0] cnt;

    // WAW blocking guarantees load only arrives once cnt has expired.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(LONG_LAT);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);
endmodule

module dual_issue_scoreboard #(
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in0_valid,
    input  logic [4:0]  in0_rs1,
    input  logic [4:0]  in0_rs2,
    input  logic [4:0]  in0_rd,
    input  logic        in0_we,
    input  logic        in0_long,
    input  logic        in1_valid,
    input  logic [4:0]  in1_rs1,
    input  logic [4:0]  in1_rs2,
    input  logic [4:0]  in1_rd,
    input  logic        in1_we,
    input  logic        in1_long,
    input  logic        flush,
    output logic        issue0,
    output logic        issue1,
    output logic        stall,
    output logic [31:0] busy_vec,
    output logic [31:0] stall_cycles
);
    logic hazard0, hazard1, intra, ld0, ld1;

    always_comb begin
        hazard0 = busy_vec[in0_rs1] | busy_vec[in0_rs2] | (in0_we & busy_vec[in0_rd]);
        hazard1 = busy_vec[in1_rs1] | busy_vec[in1_rs2] | (in1_we & busy_vec[in1_rd]);
        intra   = in0_we & (in0_rd != 5'd0) & ((in1_rs1 == in0_rd) | (in1_rs2 == in0_rd));
    end

    assign issue0 = in0_valid & ~hazard0 & ~flush & ~rst;
    assign issue1 = in1_valid & issue0 & ~hazard1 & ~intra & ~(in0_long & in1_long);
    assign stall  = in0_valid & ~issue0 & ~rst;

    assign ld0 = issue0 & in0_we & in0_long & (in0_rd != 5'd0);
    assign ld1 = issue1 & in1_we & in1_long & (in1_rd != 5'd0);

    genvar r;
    generate
        for (r = 0; r < 32; r++) begin : g_reg
            if (r == 0) begin : g_x0
                assign busy_vec[r] = 1'b0;
            end else begin : g_cnt
                dual_issue_reg_cnt #(.LONG_LAT(LONG_LAT), .CNT_W(CNT_W)) u_cnt (
                    .clk  (clk),
                    .rst  (rst),
                    .load ((ld0 & (in0_rd == 5'(r))) | (ld1 & (in1_rd == 5'(r)))),
                    .busy (busy_vec[r])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall)
            stall_cycles <= stall_cycles + 32'd1;
    end
endmodule
